// File: rtl/riscv_defines.sv
// Shared core definitions: word width, fetch buffer sizing and the fetch entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_defines;

  localparam int WORD_WIDTH       = 32;
  localparam int FETCH_FIFO_DEPTH = 4;

  // One prefetched word together with the PC it was fetched from.
  // err marks a slot whose memory response never arrived.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
    logic                  err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding fetch entries between the memory response and decode.
// Latency: one cycle from push to the entry appearing at the head (no bypass).
// Backpressure: push is ignored when full, pop when empty; flush beats push and pop.
//
// Ports: clk/rst (sync, active-high); push_i + push_dat_i write an entry;
// pop_i retires the head; flush_i empties the buffer; head_dat_o is the oldest
// entry; count_o/empty_o/full_o report occupancy.
module fetch_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_FULL);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;

    if (flush_i) begin
      // Stale storage contents are left in place; pointers and count define validity.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, requests words from instruction RAM, buffers them for decode.
// Latency: request in cycle N, response in N+1, head valid toward decode in N+2.
// Backpressure: requests stop once buffered + in-flight words reach FIFO_DEPTH; decode stalls via fetch_ready_i.
//
// Ports: clk/rst (sync, active-high); instr_req_o/instr_addr_o/instr_gnt_i/
// instr_rvalid_i/instr_rdata_i form the memory interface (response exactly one
// cycle after grant); fetch_valid_o/fetch_ready_i/fetch_instr_o/fetch_pc_o/
// fetch_err_o present the buffer head to decode; redirect_i/redirect_addr_i
// restart fetch at a new target and discard everything buffered or in flight.
module instr_fetch
  import riscv_defines::*;
#(
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  output logic                  fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic [WORD_WIDTH-1:0] fetch_instr_o,
  output logic [WORD_WIDTH-1:0] fetch_pc_o,
  output logic                  fetch_err_o,
  input  logic                  redirect_i,
  input  logic [WORD_WIDTH-1:0] redirect_addr_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WORD_WIDTH-1:0] ALIGN_MASK   = {{(WORD_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WORD_WIDTH-1:0] BOOT_ALIGNED = BOOT_ADDR & ALIGN_MASK;
  localparam logic [CNT_W:0]        OCC_LIMIT    = (CNT_W+1)'(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [WORD_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  pending_q, pending_d;
  logic                  drop_q, drop_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_ent;
  logic             push;
  logic             pop;
  logic             grant;
  logic [CNT_W:0]   occupancy;

  always_comb begin
    // Space is reserved for the in-flight word; a same-cycle pop is not
    // counted, which keeps the request path independent of fetch_ready_i.
    occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pending_q};
    instr_req_o = !rst && !redirect_i && (occupancy < OCC_LIMIT);
    grant       = instr_req_o && instr_gnt_i;

    // A pending slot with no rvalid becomes a fault entry so decode never
    // waits forever on a request the memory silently dropped.
    push           = pending_q && !drop_q && !fifo_full;
    push_ent.pc    = pend_pc_q;
    push_ent.instr = instr_rvalid_i ? instr_rdata_i : '0;
    push_ent.err   = !instr_rvalid_i;

    fetch_valid_o = !rst && !fifo_empty;
    fetch_instr_o = fetch_valid_o ? fifo_head.instr : '0;
    fetch_pc_o    = fetch_valid_o ? fifo_head.pc    : '0;
    fetch_err_o   = fetch_valid_o ? fifo_head.err   : 1'b0;
    pop           = fetch_valid_o && fetch_ready_i;

    instr_addr_o  = rst ? BOOT_ALIGNED : fetch_addr_q;

    fetch_addr_d = fetch_addr_q;
    pend_pc_d    = pend_pc_q;
    pending_d    = grant;
    drop_d       = 1'b0;

    if (redirect_i) begin
      fetch_addr_d = redirect_addr_i & ALIGN_MASK;
      // Whatever response is due next cycle belongs to the old path.
      drop_d       = pending_q || grant;
    end else if (grant) begin
      fetch_addr_d = fetch_addr_q + WORD_WIDTH'(4);
      pend_pc_d    = fetch_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q <= BOOT_ALIGNED;
      pend_pc_q    <= '0;
      pending_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      pend_pc_q    <= pend_pc_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
    end
  end

  // Redirect drives flush, which overrides any same-cycle push or pop.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .flush_i    (redirect_i),
    .head_dat_o (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 16-word instruction memory model.
// Memory answers one cycle after grant for addresses below 0x40 and stays silent above.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_err_o;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] MEM_BYTES = 32'h0000_0040;

  always #5 clk = ~clk;

  instr_fetch #(
    .BOOT_ADDR  (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .fetch_valid_o   (fetch_valid_o),
    .fetch_ready_i   (fetch_ready_i),
    .fetch_instr_o   (fetch_instr_o),
    .fetch_pc_o      (fetch_pc_o),
    .fetch_err_o     (fetch_err_o),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i)
  );

  // Program image: word 0 is ADD s0,zero,zero, word i is 0x1000_0000+i.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr[31:2] == 30'd0) return 32'h0000_0433;
    return 32'h1000_0000 | {2'b00, addr[31:2]};
  endfunction

  always @(posedge clk) begin
    if (instr_req_o && instr_gnt_i && (instr_addr_o < MEM_BYTES)) begin
      instr_rvalid_i <= 1'b1;
      instr_rdata_i  <= mem_word(instr_addr_o);
    end else begin
      instr_rvalid_i <= 1'b0;
      instr_rdata_i  <= 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int reqs;
    rst             = 1'b1;
    instr_gnt_i     = 1'b1;
    fetch_ready_i   = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_req",   32'(instr_req_o),   32'd0);
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_addr",  instr_addr_o,       32'h0);
    chk("rst_pc",    fetch_pc_o,         32'h0);
    chk("rst_instr", fetch_instr_o,      32'h0);
    chk("rst_err",   32'(fetch_err_o),   32'd0);

    // Streaming from boot with decode always ready
    rst = 1'b0; fetch_ready_i = 1'b1; #1;
    chk("t1_c0_req",  32'(instr_req_o), 32'd1);
    chk("t1_c0_addr", instr_addr_o,     32'h00);
    step();
    chk("t1_c1_addr",  instr_addr_o,       32'h04);
    chk("t1_c1_valid", 32'(fetch_valid_o), 32'd0);
    step();
    chk("t1_c2_addr",  instr_addr_o,       32'h08);
    chk("t1_c2_valid", 32'(fetch_valid_o), 32'd1);
    chk("t1_c2_pc",    fetch_pc_o,         32'h00);
    chk("t1_c2_instr", fetch_instr_o,      32'h0000_0433);
    chk("t1_c2_err",   32'(fetch_err_o),   32'd0);
    step();
    chk("t1_c3_pc",    fetch_pc_o,    32'h04);
    chk("t1_c3_instr", fetch_instr_o, 32'h1000_0001);
    step();
    chk("t1_c4_pc",    fetch_pc_o,    32'h08);
    chk("t1_c4_instr", fetch_instr_o, 32'h1000_0002);

    // Decode stalled: exactly four requests fill the buffer
    rst = 1'b1; step();
    rst = 1'b0; fetch_ready_i = 1'b0; #1;
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      reqs += int'(instr_req_o);
      step();
    end
    chk("t2_req_count", 32'(reqs),          32'd4);
    chk("t2_full_req",  32'(instr_req_o),   32'd0);
    chk("t2_full_addr", instr_addr_o,       32'h10);
    chk("t2_full_pc",   fetch_pc_o,         32'h00);
    fetch_ready_i = 1'b1; #1;
    chk("t2_pop_no_req", 32'(instr_req_o), 32'd0);
    step();
    chk("t2_c9_pc",   fetch_pc_o,       32'h04);
    chk("t2_c9_req",  32'(instr_req_o), 32'd1);
    chk("t2_c9_addr", instr_addr_o,     32'h10);
    step();
    chk("t2_c10_pc", fetch_pc_o, 32'h08);
    step();
    chk("t2_c11_pc", fetch_pc_o, 32'h0c);
    step();
    chk("t2_c12_pc",    fetch_pc_o,    32'h10);
    chk("t2_c12_instr", fetch_instr_o, 32'h1000_0004);

    // Redirect to 0x0c the cycle after 0x10 is granted
    rst = 1'b1; step();
    rst = 1'b0; fetch_ready_i = 1'b1; #1;
    step(); step(); step(); step();
    chk("t3_c4_addr", instr_addr_o,     32'h10);
    chk("t3_c4_req",  32'(instr_req_o), 32'd1);
    step();
    redirect_i = 1'b1; redirect_addr_i = 32'h0c; #1;
    chk("t3_redir_req", 32'(instr_req_o), 32'd0);
    chk("t3_redir_pc",  fetch_pc_o,       32'h0c);
    step();
    redirect_i = 1'b0; #1;
    chk("t3_c6_addr",  instr_addr_o,       32'h0c);
    chk("t3_c6_req",   32'(instr_req_o),   32'd1);
    chk("t3_c6_valid", 32'(fetch_valid_o), 32'd0);
    step();
    chk("t3_c7_valid", 32'(fetch_valid_o), 32'd0);
    step();
    chk("t3_c8_valid", 32'(fetch_valid_o), 32'd1);
    chk("t3_c8_pc",    fetch_pc_o,         32'h0c);
    chk("t3_c8_instr", fetch_instr_o,      32'h1000_0003);
    step();
    chk("t3_c9_pc", fetch_pc_o, 32'h10);

    // Unaligned redirect target is forced to a word boundary
    redirect_i = 1'b1; redirect_addr_i = 32'h1E; #1;
    step();
    redirect_i = 1'b0; #1;
    chk("t4_addr", instr_addr_o,     32'h1C);
    chk("t4_req",  32'(instr_req_o), 32'd1);
    step();
    chk("t4_flushed", 32'(fetch_valid_o), 32'd0);
    step();
    chk("t4_pc",    fetch_pc_o,    32'h1C);
    chk("t4_instr", fetch_instr_o, 32'h1000_0007);

    // Running off the end of memory produces fault entries
    redirect_i = 1'b1; redirect_addr_i = 32'h3C; #1;
    step();
    redirect_i = 1'b0; #1;
    chk("t5_addr3c", instr_addr_o, 32'h3C);
    step();
    chk("t5_addr40", instr_addr_o, 32'h40);
    step();
    chk("t5_pc3c",    fetch_pc_o,       32'h3C);
    chk("t5_instr3c", fetch_instr_o,    32'h1000_000F);
    chk("t5_err3c",   32'(fetch_err_o), 32'd0);
    chk("t5_addr44",  instr_addr_o,     32'h44);
    step();
    chk("t5_pc40",    fetch_pc_o,       32'h40);
    chk("t5_instr40", fetch_instr_o,    32'h0);
    chk("t5_err40",   32'(fetch_err_o), 32'd1);
    chk("t5_addr48",  instr_addr_o,     32'h48);
    step();
    chk("t5_pc44",  fetch_pc_o,       32'h44);
    chk("t5_err44", 32'(fetch_err_o), 32'd1);

    // Reset while buffer is reserved-full with a response in flight
    rst = 1'b1; step();
    rst = 1'b0; fetch_ready_i = 1'b0; #1;
    step(); step(); step(); step();
    chk("t6_pre_req",   32'(instr_req_o),   32'd0);
    chk("t6_pre_valid", 32'(fetch_valid_o), 32'd1);
    rst = 1'b1; #1;
    chk("t6_rst_req",   32'(instr_req_o),   32'd0);
    chk("t6_rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("t6_rst_addr",  instr_addr_o,       32'h0);
    chk("t6_rst_pc",    fetch_pc_o,         32'h0);
    step();
    rst = 1'b0; fetch_ready_i = 1'b1; #1;
    chk("t6_c0_valid", 32'(fetch_valid_o), 32'd0);
    chk("t6_c0_req",   32'(instr_req_o),   32'd1);
    chk("t6_c0_addr",  instr_addr_o,       32'h0);
    step();
    chk("t6_c1_valid", 32'(fetch_valid_o), 32'd0);
    step();
    chk("t6_c2_pc",    fetch_pc_o,    32'h0);
    chk("t6_c2_instr", fetch_instr_o, 32'h0000_0433);
    step();
    chk("t6_c3_pc", fetch_pc_o, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
